// File: rtl/bin2bcd_pkg.sv
// rtl/bin2bcd_pkg.sv - shared types and constants for the sequential binary-to-BCD converter
// Contents:
//   state_t   : converter FSM states (IDLE, SHIFT, DONE)
//   BCD_BLANK : nibble code shown in place of a suppressed leading zero
//   bcd_ndig  : number of decimal digits needed for a w-bit unsigned value
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Each decimal digit covers log2(10) ~ 3.32 bits, so ceil(w/3) digits
    // always suffices.
    function automatic int bcd_ndig(input int w);
        return (w + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// rtl/bcd_digit_adj.sv - double-dabble per-digit correction (add 3 when digit > 4)
// Ports:
//   din  : input  [3:0] current BCD digit
//   dout : output [3:0] digit after conditional +3, ready for the left shift
module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // A digit of 5..9 becomes 8..12, so the following shift carries into the
    // next digit exactly when the doubled value would reach 10 or more.
    always_comb begin
        dout = (din > 4'd4) ? (din + 4'd3) : din;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential shift-and-add-3 binary to BCD converter, one bit per cycle
// Parameters:
//   W    : binary input width (W >= 4)
//   NDIG : number of BCD digits produced (default ceil(W/3))
// Ports:
//   clock     : input           rising-edge clock
//   reset     : input           asynchronous active-high reset
//   in_valid  : input           bin is offered
//   in_ready  : output          converter is idle and accepts bin
//   bin       : input  [W-1:0]  unsigned binary value
//   out_valid : output          bcd holds a finished result
//   out_ready : input           consumer takes the result
//   bcd       : output [4*NDIG-1:0] digits {MSD,...,tens,ones}, ones in [3:0]
//   busy      : output          conversion in progress
// Build option:
//   BIN2BCD_BLANK_EN : replace leading zero digits (never the ones digit) with BCD_BLANK
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W    = 32,
    parameter int NDIG = bcd_ndig(W)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W-1:0]        bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*NDIG-1:0]   bcd,
    output logic                busy
);

    localparam int DW = 4 * NDIG;
    localparam int CW = $clog2(W + 1);

    state_t             state;
    logic [W-1:0]       bin_sr;
    logic [DW-1:0]      digits;
    logic [DW-1:0]      adj;
    logic [DW-1:0]      blanked;
    logic [DW+W-1:0]    shifted;
    logic [CW-1:0]      cnt;

    genvar g;
    generate
        for (g = 0; g < NDIG; g++) begin : g_adj
            bcd_digit_adj u_adj (
                .din  (digits[4*g +: 4]),
                .dout (adj[4*g +: 4])
            );
        end
    endgenerate

    // Digits and remaining binary bits shift as one register; the bit pushed
    // out of the top digit is always zero because NDIG digits cover 2^W-1.
    assign shifted = {adj, bin_sr} << 1;

`ifdef BIN2BCD_BLANK_EN
    always_comb begin
        logic lead;
        blanked = shifted[DW+W-1:W];
        lead    = 1'b1;
        for (int i = NDIG - 1; i >= 1; i--) begin
            if (lead && (blanked[4*i +: 4] == 4'h0)) begin
                blanked[4*i +: 4] = BCD_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
    end
`else
    always_comb begin
        blanked = shifted[DW+W-1:W];
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bin_sr    <= '0;
            digits    <= '0;
            cnt       <= '0;
            bcd       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr   <= bin;
                        digits   <= '0;
                        cnt      <= CW'(W);
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    digits <= shifted[DW+W-1:W];
                    bin_sr <= shifted[W-1:0];
                    cnt    <= cnt - CW'(1);
                    // Final shift: publish the completed digits directly so
                    // out_valid rises exactly W cycles after the accept edge.
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        bcd       <= blanked;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - scoreboard bench for bin2bcd_seq (W=32) with directed vectors
module tb_bin2bcd_seq;

    localparam int W    = 32;
    localparam int NDIG = 11;
    localparam int DW   = 4 * NDIG;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   bin = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [DW-1:0]  bcd;
    logic           busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [DW-1:0] exp_q[$];
    int            acc_q[$];

    bin2bcd_seq #(.W(W), .NDIG(NDIG)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .busy      (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [DW-1:0] blank_exp(input logic [DW-1:0] e);
        logic [DW-1:0] r;
        r = e;
`ifdef BIN2BCD_BLANK_EN
        begin
            bit lead;
            lead = 1'b1;
            for (int i = NDIG - 1; i >= 1; i--) begin
                if (lead && r[4*i +: 4] == 4'h0) r[4*i +: 4] = 4'hF;
                else lead = 1'b0;
            end
        end
`endif
        return r;
    endfunction

    task automatic check1(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic send(input logic [W-1:0] v, input logic [DW-1:0] e);
        int n;
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        check1("accept_wait", DW'(in_ready), DW'(1));
        in_valid = 1'b1;
        bin      = v;
        exp_q.push_back(blank_exp(e));
        acc_q.push_back(cyc + 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        @(negedge clock);
        check1("in_ready_in_shift", DW'(in_ready), DW'(0));
        check1("busy_in_shift", DW'(busy), DW'(1));
    endtask

    // Monitor: latency on each rising out_valid, data on each handshake.
    initial begin
        logic          prev_valid;
        logic [DW-1:0] e;
        int            a;
        prev_valid = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (out_valid && !prev_valid) begin
                    checks++;
                    if (acc_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_out_valid actual=1 required=0 cyc=%0d", cyc);
                    end else begin
                        a = acc_q.pop_front();
                        if (cyc - a != W) begin
                            failures++;
                            $display("FAIL latency actual=%0d required=%0d", cyc - a, W);
                        end
                    end
                end
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check1("bcd_result", bcd, e);
                end
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        int n;
        logic [DW-1:0] stall_exp;

        // reset state
        #12;
        check1("rst_in_ready", DW'(in_ready), DW'(1));
        check1("rst_out_valid", DW'(out_valid), DW'(0));
        check1("rst_busy", DW'(busy), DW'(0));
        check1("rst_bcd", bcd, '0);
        @(negedge clock);
        reset = 1'b0;

        // directed vectors, back-to-back with out_ready=1
        send(32'd1234,       44'h000_0000_1234);
        send(32'd4294967295, 44'h042_9496_7295);
        send(32'd0,          44'h000_0000_0000);
        send(32'd9,          44'h000_0000_0009);
        send(32'd10,         44'h000_0000_0010);
        send(32'd99999999,   44'h000_9999_9999);
        send(32'd1000000000, 44'h010_0000_0000);
        send(32'd2147483648, 44'h021_4748_3648);

        // stall: hold out_ready low for 10 cycles, pulse in_valid meanwhile
        n = 0;
        @(negedge clock);
        while (!in_ready && n < 300) begin @(negedge clock); n++; end
        out_ready = 1'b0;
        stall_exp = blank_exp(44'h009_8765_4321);
        send(32'd987654321, 44'h009_8765_4321);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clock); n++; end
        check1("stall_valid_wait", DW'(out_valid), DW'(1));
        for (int i = 0; i < 10; i++) begin
            @(posedge clock);
            #1;
            in_valid = (i % 2 == 0);
            bin      = 32'd5;
            @(negedge clock);
            check1("stall_out_valid", DW'(out_valid), DW'(1));
            check1("stall_bcd", bcd, stall_exp);
            check1("stall_in_ready", DW'(in_ready), DW'(0));
        end
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check1("post_hs_in_ready", DW'(in_ready), DW'(1));
        check1("post_hs_bcd_retained", bcd, stall_exp);
        check1("post_hs_busy", DW'(busy), DW'(0));

        // reset in the middle of a conversion
        send(32'd55555, 44'h000_0005_5555);
        repeat (14) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        exp_q.delete();
        acc_q.delete();
        check1("midrst_in_ready", DW'(in_ready), DW'(1));
        check1("midrst_out_valid", DW'(out_valid), DW'(0));
        check1("midrst_busy", DW'(busy), DW'(0));
        check1("midrst_bcd", bcd, '0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        send(32'd4000000000, 44'h040_0000_0000);

        // drain
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin @(negedge clock); n++; end
        check1("drain_empty", DW'(exp_q.size()), DW'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
